control_sequencer: RTL

- Multi-cycle control unit directly upstream of the RISC datapath.
- Fetches, decodes and sequences each instruction, driving every bus-select, register-enable, ALU-op and memory strobe the datapath consumes.
- Consumes the IR contents and a memory-ready handshake.
- Moore FSM: all outputs decode from the current state plus IR fields only.

---
 rtl/control_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle fetch/decode/execute control FSM for the RISC datapath; optional MEM_TIMEOUT_EN bounds memory waits
module control_sequencer #(
    parameter logic [4:0] INC_OP         = 5'd31,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [15:0] reg_out,
    output logic [15:0] reg_in,
    output logic        pc_out,
    output logic        mdr_out,
    output logic        hi_out,
    output logic        lo_out,
    output logic        zhigh_out,
    output logic        zlow_out,
    output logic        c_out,
    output logic        inport_out,
    output logic        pc_in,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        mdr_in,
    output logic        mar_in,
    output logic        hi_in,
    output logic        lo_in,
    output logic        read,
    output logic        write,
    output logic [4:0]  alu_op,
    output logic [31:0] c_value,
    output logic        halted,
    output logic        illegal,
    output logic        mem_fault
);

    typedef enum logic [3:0] {RST, F0, F1, F2, T3, T4, T5, T6, T7, HALT} stateType;

    stateType state, nextState;

    logic [4:0]  op;
    logic [15:0] raSel, rbSel, rcSel;
    logic        isR, isI, isLd, isSt, isMulDiv, isNegNot, isMfhi, isMflo, isHalt, isIllegal;
    logic [4:0]  execAlu;
    logic        waiting, timeoutHit;

    assign op      = ir[31:27];
    assign raSel   = 16'd1 << ir[26:23];
    assign rbSel   = 16'd1 << ir[22:19];
    assign rcSel   = 16'd1 << ir[18:15];
    assign c_value = {{13{ir[18]}}, ir[18:0]};

    assign isR       = (op <= 5'd8);
    assign isI       = (op >= 5'd9) && (op <= 5'd11);
    assign isLd      = (op == 5'd12);
    assign isSt      = (op == 5'd13);
    assign isMulDiv  = (op == 5'd14) || (op == 5'd15);
    assign isNegNot  = (op == 5'd16) || (op == 5'd17);
    assign isMfhi    = (op == 5'd18);
    assign isMflo    = (op == 5'd19);
    assign isHalt    = (op == 5'd21);
    assign isIllegal = (op >= 5'd22);

    // States that sit waiting for mem_ready
    assign waiting = (state == F1) || ((state == T6) && isLd) || ((state == T7) && isSt);

    // Immediate ops map onto the add/and/or ALU codes; everything else passes op through
    always_comb begin
        execAlu = op;
        if (op == 5'd9)       execAlu = 5'd0;
        else if (op == 5'd10) execAlu = 5'd2;
        else if (op == 5'd11) execAlu = 5'd3;
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] waitCnt;
    logic          memFault;

    assign timeoutHit = waiting && !mem_ready && (waitCnt == CW'(TIMEOUT_CYCLES - 1));
    assign mem_fault  = memFault;

    // Wait counter restarts whenever a wait state is (re)entered; fault is sticky until reset
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            waitCnt  <= '0;
            memFault <= 1'b0;
        end else begin
            if (!waiting)        waitCnt <= '0;
            else if (!mem_ready) waitCnt <= waitCnt + CW'(1);
            if (timeoutHit)      memFault <= 1'b1;
        end
    end
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = ^TIMEOUT_CYCLES;
    assign timeoutHit       = 1'b0;
    assign mem_fault        = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= RST;
        else        state <= nextState;
    end

    // Next-state sequencing
    always_comb begin
        nextState = state;
        case (state)
            RST:  nextState = F0;
            F0:   nextState = F1;
            F1:   nextState = timeoutHit ? HALT : (mem_ready ? F2 : F1);
            F2:   nextState = T3;
            T3:   nextState = isHalt ? HALT :
                              (isMfhi || isMflo || !(isR || isI || isLd || isSt || isMulDiv || isNegNot)) ? F0 : T4;
            T4:   nextState = T5;
            T5:   nextState = (isLd || isSt || isMulDiv) ? T6 : F0;
            T6:   nextState = isLd ? (timeoutHit ? HALT : (mem_ready ? T7 : T6)) :
                              isSt ? T7 : F0;
            T7:   nextState = isSt ? (timeoutHit ? HALT : (mem_ready ? F0 : T7)) : F0;
            HALT: nextState = HALT;
            default: nextState = RST;
        endcase
    end

    // Moore output decode from state and IR fields
    always_comb begin
        reg_out = '0;  reg_in = '0;
        pc_out = 1'b0; mdr_out = 1'b0; hi_out = 1'b0; lo_out = 1'b0;
        zhigh_out = 1'b0; zlow_out = 1'b0; c_out = 1'b0; inport_out = 1'b0;
        pc_in = 1'b0; ir_in = 1'b0; y_in = 1'b0; z_in = 1'b0;
        mdr_in = 1'b0; mar_in = 1'b0; hi_in = 1'b0; lo_in = 1'b0;
        read = 1'b0; write = 1'b0; alu_op = '0; halted = 1'b0; illegal = 1'b0;
        case (state)
            F0: begin pc_out = 1'b1; mar_in = 1'b1; z_in = 1'b1; alu_op = INC_OP; end
            F1: begin zlow_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1; end
            F2: begin mdr_out = 1'b1; ir_in = 1'b1; end
            T3: begin
                alu_op  = execAlu;
                illegal = isIllegal;
                if (isR || isI || isLd || isSt) begin reg_out = rbSel; y_in = 1'b1; end
                else if (isMulDiv)              begin reg_out = raSel; y_in = 1'b1; end
                else if (isMfhi)                begin hi_out = 1'b1; reg_in = raSel; end
                else if (isMflo)                begin lo_out = 1'b1; reg_in = raSel; end
            end
            T4: begin
                alu_op = execAlu;
                if (isR)                          begin reg_out = rcSel; z_in = 1'b1; end
                else if (isNegNot || isMulDiv)    begin reg_out = rbSel; z_in = 1'b1; end
                else if (isI)                     begin c_out = 1'b1; z_in = 1'b1; end
                else if (isLd || isSt)            begin c_out = 1'b1; z_in = 1'b1; alu_op = 5'd0; end
            end
            T5: begin
                alu_op   = execAlu;
                zlow_out = 1'b1;
                if (isLd || isSt)  mar_in = 1'b1;
                else if (isMulDiv) lo_in  = 1'b1;
                else               reg_in = raSel;
            end
            T6: begin
                alu_op = execAlu;
                if (isLd)      begin read = 1'b1; mdr_in = 1'b1; end
                else if (isSt) begin reg_out = raSel; mdr_in = 1'b1; end
                else           begin zhigh_out = 1'b1; hi_in = 1'b1; end
            end
            T7: begin
                alu_op = execAlu;
                if (isLd) begin mdr_out = 1'b1; reg_in = raSel; end
                else      write = 1'b1;
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule
